// File: rtl/wc_tile_former.sv
// Purpose : forms overlapping 9-sample tiles (stride M, overlap R-1) from a serial
//           sample stream for the 1-D Winograd F(5,5) core; zero-pads the last tile of a row.
// Latency : the sample completing a tile is accepted in cycle t, the tile is loaded in t+1,
//           and tile_valid is high from t+2.
// Backpressure: in_ready drops while padding, or when the window is full and the output
//           register is occupied and not being consumed; D/tile_valid hold until tile_ready.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input sample handshake; in_data sample, in_last marks end of row
//   tile_valid/tile_ready  output tile handshake; D packed tile (sample 0 oldest in D[W-1:0])
//   tile_last              tile is the final (possibly zero-padded) tile of its row
module wc_tile_former #(
    parameter int W = 10,
    parameter int M = 5,
    parameter int R = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic                     in_last,
    output logic                     tile_valid,
    input  logic                     tile_ready,
    output logic [(M+R-1)*W-1:0]     D,
    output logic                     tile_last
);

    localparam int N  = M + R - 1;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] CNT_FULL     = CW'(N);
    // Samples kept after a tile leaves: the R-1 overlap, plus one when a new
    // sample is shifted in during the same cycle.
    localparam logic [CW-1:0] CNT_KEEP     = CW'(R - 1);
    localparam logic [CW-1:0] CNT_KEEP_ACC = CW'(R);

    typedef enum logic {FILL, PAD} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   win [N];

    logic full;
    logic out_free;
    logic xfer;
    logic accept;
    logic pad_shift;
    logic shift;

    assign full      = (cnt == CNT_FULL);
    assign out_free  = !tile_valid || tile_ready;
    assign xfer      = full && out_free;
    assign in_ready  = !rst && (state == FILL) && (!full || xfer);
    assign accept    = in_valid && in_ready;
    assign pad_shift = (state == PAD) && !full;
    assign shift     = accept || pad_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                win[i] <= '0;
            end
            cnt        <= '0;
            state      <= FILL;
            D          <= '0;
            tile_valid <= 1'b0;
            tile_last  <= 1'b0;
        end else begin
            // Window shift: new sample (or a pad zero) enters at the young end.
            if (shift) begin
                for (int i = 0; i < N - 1; i++) begin
                    win[i] <= win[i+1];
                end
                win[N-1] <= pad_shift ? '0 : in_data;
            end

            // Output register. The window is sampled before this cycle's shift,
            // so a same-cycle accept does not disturb the outgoing tile.
            if (xfer) begin
                for (int k = 0; k < N; k++) begin
                    D[k*W +: W] <= win[k];
                end
                tile_valid <= 1'b1;
                tile_last  <= (state == PAD);
            end else if (tile_ready) begin
                tile_valid <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (xfer && accept) begin
                        cnt <= CNT_KEEP_ACC;
                    end else if (xfer) begin
                        cnt <= CNT_KEEP;
                    end else if (accept) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (accept && in_last) begin
                        state <= PAD;
                    end
                end
                PAD: begin
                    // No overlap is carried into the next row.
                    if (xfer) begin
                        cnt   <= '0;
                        state <= FILL;
                    end else if (!full) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_wc_tile_former.sv
// Purpose : randomized and directed checks of wc_tile_former against a row-level tile model.
// Latency : n/a (testbench).
// Backpressure: tile_ready is driven randomly, or held low for a window after a tile appears.
module tb_wc_tile_former;

    localparam int W  = 10;
    localparam int N  = 9;
    localparam int DW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          tile_valid;
    logic          tile_ready;
    logic [DW-1:0] D;
    logic          tile_last;

    wc_tile_former dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .D          (D),
        .tile_last  (tile_last)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Row-level reference: a row of L samples yields tiles at offsets 0,5,10,...
    // until a tile reaches past the final sample; positions beyond L are zero,
    // and the final tile of the row carries the last flag.
    logic [W-1:0] row_buf [$];
    logic [DW:0]  exp_q   [$];
    logic [DW:0]  got_q   [$];

    function automatic void close_row();
        int L;
        int K;
        logic [DW:0] t;
        L = row_buf.size();
        K = (L <= N) ? 1 : ((L - N + 4) / 5 + 1);
        for (int k = 0; k < K; k++) begin
            t = '0;
            for (int j = 0; j < N; j++) begin
                if (5 * k + j < L) t[W*j +: W] = row_buf[5*k + j];
            end
            t[DW] = (k == K - 1);
            exp_q.push_back(t);
        end
        row_buf.delete();
    endfunction

    function automatic logic [DW:0] seq_tile(input int first, input int count, input logic last);
        logic [DW:0] t;
        t = '0;
        for (int j = 0; j < count; j++) t[W*j +: W] = W'(first + j);
        t[DW] = last;
        return t;
    endfunction

    // Monitor: everything is sampled on the falling edge, where inputs and
    // outputs are stable for the coming rising edge.
    logic [DW:0] prev_out;
    logic        stall_prev = 1'b0;
    int          ready_low = 0;

    always @(negedge clk) begin
        if (rst) begin
            row_buf.delete();
            exp_q.delete();
            got_q.delete();
            stall_prev = 1'b0;
            check("rst_in_ready", 128'(in_ready), 128'(0));
        end else begin
            if (stall_prev) begin
                check("hold_valid", 128'(tile_valid), 128'(1));
                check("hold_tile", 128'({tile_last, D}), 128'(prev_out));
            end
            stall_prev = tile_valid && !tile_ready;
            prev_out   = {tile_last, D};
            if (!in_ready) ready_low++;
            if (in_valid && in_ready) begin
                row_buf.push_back(in_data);
                if (in_last) close_row();
            end
            if (tile_valid && tile_ready) got_q.push_back({tile_last, D});
            while (got_q.size() > 0 && exp_q.size() > 0) begin
                check("tile", 128'(got_q.pop_front()), 128'(exp_q.pop_front()));
            end
        end
    end

    // Output backpressure: random, or a 10-cycle stall on request.
    int bp_pct   = 0;
    int hold_req = 0;

    initial begin
        int hold_seen;
        hold_seen  = 0;
        tile_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_req != hold_seen && tile_valid) begin
                tile_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                hold_seen = hold_req;
            end
            tile_ready = ($urandom_range(0, 99) >= bp_pct);
        end
    end

    task automatic send(input logic [W-1:0] d, input logic last, input int gap_pct);
        bit acc;
        int t;
        while ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc = 1'b0;
        t   = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 300) begin
                check("accept_timeout", 128'(0), 128'(1));
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_seq(input int first, input int count, input logic last_on_end, input int gap_pct);
        for (int i = 0; i < count; i++) begin
            send(W'(first + i), last_on_end && (i == count - 1), gap_pct);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || got_q.size() != 0 || row_buf.size() != 0) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_pending", 128'(exp_q.size() + got_q.size() + row_buf.size()), 128'(0));
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_tile_valid", 128'(tile_valid), 128'(0));
        check("rst_D", 128'(D), 128'(0));
        check("rst_tile_last", 128'(tile_last), 128'(0));
        rst = 1'b0;
    endtask

    initial begin
        int low0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_tile_valid", 128'(tile_valid), 128'(0));
        check("reset_D", 128'(D), 128'(0));
        check("reset_tile_last", 128'(tile_last), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", 128'(in_ready), 128'(1));

        // Continuous stream without a row end: two tiles, no stall.
        low0 = ready_low;
        send_seq(1, 14, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("s1_tile_count", 128'(got_q.size()), 128'(2));
        if (got_q.size() > 0) check("s1_tile0", 128'(got_q[0]), 128'(seq_tile(1, 9, 1'b0)));
        if (got_q.size() > 1) check("s1_tile1", 128'(got_q[1]), 128'(seq_tile(6, 9, 1'b0)));
        check("s1_in_ready_low", 128'(ready_low - low0), 128'(0));

        // Mid-row reset discards the partial window.
        pulse_rst();
        send_seq(1, 6, 1'b0, 0);
        pulse_rst();
        send_seq(31, 9, 1'b1, 0);
        drain();

        // Row of 12: second tile padded with two zeros; 3 stalled input cycles.
        low0 = ready_low;
        send_seq(1, 12, 1'b1, 0);
        drain();
        check("s2_in_ready_low", 128'(ready_low - low0), 128'(3));

        // Short row then a fresh row: nothing carries over.
        send_seq(1, 3, 1'b1, 0);
        send_seq(21, 10, 1'b1, 0);
        drain();

        // Exact fit: single tile, only the transfer cycle stalls input.
        low0 = ready_low;
        send_seq(1, 9, 1'b1, 0);
        drain();
        check("s5_in_ready_low", 128'(ready_low - low0), 128'(1));

        // Output stall after the first tile.
        hold_req = hold_req + 1;
        send_seq(1, 20, 1'b1, 0);
        drain();

        // Randomized rows, gaps and backpressure.
        bp_pct = 30;
        for (int r = 0; r < 30; r++) begin
            int len;
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) send(W'($urandom), i == len - 1, 25);
        end
        drain();
        bp_pct = 70;
        for (int r = 0; r < 15; r++) begin
            int len;
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) send(W'($urandom), i == len - 1, 10);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
